// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the paced round-robin FIFO reader.
//   state_t : reader FSM states (SCAN = looking for a read, GAP = holdoff)
//   clog2   : ceil(log2(n)), never less than 1 so single-channel builds
//             still get a 1-bit channel tag
package fifo_rd_pkg;

  typedef enum logic {SCAN = 1'b0, GAP = 1'b1} state_t;

  localparam int DEF_DW      = 8;
  localparam int DEF_NCH     = 4;
  localparam int DEF_MIN_GAP = 2;
  localparam int DEF_GAPW    = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : per-channel request
//   ptr : last granted channel; search starts at ptr+1 and wraps
//   gnt : one-hot grant
//   idx : index of granted channel
//   any : at least one request present
module rr_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx,
  output logic           any
);

  int c;

  // Walk ptr+1 .. ptr+NCH (mod NCH); the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 1; i <= NCH; i++) begin
      c = (int'(ptr) + i) % NCH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CW'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_reader.sv
// Paced multi-channel FIFO reader. Drains NCH show-ahead FIFOs round-robin
// into one tagged stream, forcing MIN_GAP + cfg_gap idle cycles after every
// read.
//   clk, rstx : clock (rising) / async active-low reset
//   en        : allow new reads (a running gap keeps counting regardless)
//   cfg_gap   : extra idle cycles, sampled in the read cycle
//   data      : channel c at [c*DW +: DW]
//   avail     : channel FIFO non-empty
//   ready     : downstream accept (only when FIFORDR_READY_EN is defined)
//   ack       : one-hot read strobe back to the FIFOs
//   q, ch, dv : registered sample, source channel, valid
// Build option FIFORDR_READY_EN: adds ready; q/ch/dv hold until accepted.
// Without it dv is a single-cycle pulse and q/ch fall back to 0.
module fifo_rr_reader
  import fifo_rd_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int NCH     = DEF_NCH,
  parameter int MIN_GAP = DEF_MIN_GAP,
  parameter int GAPW    = DEF_GAPW,
  localparam int CW     = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rstx,
  input  logic              en,
  input  logic [GAPW-1:0]   cfg_gap,
  input  logic [NCH*DW-1:0] data,
  input  logic [NCH-1:0]    avail,
`ifdef FIFORDR_READY_EN
  input  logic              ready,
`endif
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     q,
  output logic [CW-1:0]     ch,
  output logic              dv
);

  state_t          state, state_nxt;
  logic [GAPW:0]   cnt, load;
  logic [CW-1:0]   ptr, gidx;
  logic [NCH-1:0]  gnt;
  logic            gany, out_free, rd;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req (avail),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // One extra bit on the counter so MIN_GAP + max cfg_gap cannot wrap.
  assign load = (GAPW+1)'(MIN_GAP) + {1'b0, cfg_gap};

`ifdef FIFORDR_READY_EN
  // The output slot frees up on the same edge it is accepted.
  assign out_free = !dv || ready;
`else
  assign out_free = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) state <= SCAN;
    else       state <= state_nxt;
  end

  // Next state; a zero-length gap keeps us in SCAN for back-to-back reads.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (rd && load != '0) state_nxt = GAP;
      GAP:     if (cnt == (GAPW+1)'(1)) state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // FSM output: read fires only while scanning.
  always_comb begin
    rd = 1'b0;
    if (state == SCAN && en && gany && out_free) rd = 1'b1;
  end

  // Gap counter: loaded on a read, counts down to 0 in GAP.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx)          cnt <= '0;
    else if (rd)        cnt <= load;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  // Arbiter pointer: starts at NCH-1 so channel 0 goes first after reset.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx)   ptr <= CW'(NCH-1);
    else if (rd) ptr <= gidx;
  end

  // Output registers
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      ack <= '0;
      q   <= '0;
      ch  <= '0;
      dv  <= 1'b0;
    end else begin
      ack <= rd ? gnt : '0;
      if (rd) begin
        q  <= data[int'(gidx)*DW +: DW];
        ch <= gidx;
        dv <= 1'b1;
      end else begin
`ifdef FIFORDR_READY_EN
        if (dv && ready) dv <= 1'b0;
`else
        q  <= '0;
        ch <= '0;
        dv <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Directed bench for fifo_rr_reader: an NCH=1 instance for the legacy rate,
// an NCH=4 instance for arbitration, gap, enable, reset and (when
// FIFORDR_READY_EN is defined) backpressure.
module tb_fifo_rr_reader;

  logic        clk = 1'b0;
  logic        rstx;
  logic        en;
  logic [7:0]  cfg_gap;
  logic [7:0]  data1;
  logic [0:0]  avail1;
  logic [31:0] data4;
  logic [3:0]  avail4;
`ifdef FIFORDR_READY_EN
  logic        ready;
`endif
  logic [0:0]  ack1;
  logic [7:0]  q1;
  logic [0:0]  ch1;
  logic        dv1;
  logic [3:0]  ack4;
  logic [7:0]  q4;
  logic [1:0]  ch4;
  logic        dv4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_rr_reader #(.DW(8), .NCH(1), .MIN_GAP(2), .GAPW(8)) u1 (
    .clk(clk), .rstx(rstx), .en(en), .cfg_gap(cfg_gap),
    .data(data1), .avail(avail1),
`ifdef FIFORDR_READY_EN
    .ready(ready),
`endif
    .ack(ack1), .q(q1), .ch(ch1), .dv(dv1)
  );

  fifo_rr_reader #(.DW(8), .NCH(4), .MIN_GAP(2), .GAPW(8)) u4 (
    .clk(clk), .rstx(rstx), .en(en), .cfg_gap(cfg_gap),
    .data(data4), .avail(avail4),
`ifdef FIFORDR_READY_EN
    .ready(ready),
`endif
    .ack(ack4), .q(q4), .ch(ch4), .dv(dv4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until u4 strobes ack (or the bound runs out); n = edges waited.
  task automatic wait_read(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack4 == '0 && n < bound);
  endtask

  task automatic rd4(input string tag, input int sp, input int c);
    int n;
    wait_read(sp + 5, n);
    chk({tag, " spacing"}, n, sp);
    chk({tag, " ch"}, ch4, c);
    chk({tag, " q"}, q4, 8'hC0 + c);
    chk({tag, " ack"}, ack4, 32'd1 << c);
    chk({tag, " dv"}, dv4, 1);
  endtask

  initial begin
    int acks;
    logic [7:0] lq;

    rstx    = 1'b0;
    en      = 1'b1;
    cfg_gap = 8'd0;
    data1   = 8'hA5;
    avail1  = 1'b1;
    data4   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    avail4  = 4'hF;
`ifdef FIFORDR_READY_EN
    ready   = 1'b1;
`endif

    // Reset held with everything available: nothing moves.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst ack4", ack4, 0);
      chk("rst dv4", dv4, 0);
      chk("rst q4", q4, 0);
      chk("rst ack1", ack1, 0);
      chk("rst dv1", dv1, 0);
    end

    // Legacy rate on the single-channel reader: reads on edges 1, 4, 7.
    avail4 = 4'h0;
    rstx   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("legacy dv c%0d", k), dv1, (k % 3 == 1));
      chk($sformatf("legacy ack c%0d", k), ack1, (k % 3 == 1));
`ifdef FIFORDR_READY_EN
      chk($sformatf("legacy q c%0d", k), q1, 8'hA5);
`else
      chk($sformatf("legacy q c%0d", k), q1, (k % 3 == 1) ? 8'hA5 : 8'h00);
`endif
      chk($sformatf("legacy ch c%0d", k), ch1, 0);
    end
    avail1 = 1'b0;

    // Round-robin over channels 0,1,3.
    rstx = 1'b0;
    tick();
    rstx   = 1'b1;
    avail4 = 4'b1011;
    rd4("rr1", 1, 0);
    rd4("rr2", 3, 1);
    rd4("rr3", 3, 3);
    rd4("rr4", 3, 0);
    rd4("rr5", 3, 1);
    rd4("rr6", 3, 3);
    avail4 = 4'b1001;           // channel 1 drops out while in GAP
    rd4("rr7", 3, 0);
    rd4("rr8", 3, 3);
    rd4("rr9", 3, 0);

    // Programmable gap; a mid-gap change only affects the following read.
    cfg_gap = 8'd5;
    rd4("gap1", 3, 3);
    rd4("gap2", 8, 0);
    cfg_gap = 8'd0;
    rd4("gap3", 8, 3);
    rd4("gap4", 3, 0);

    // en=0 blocks reads; re-enabling reads on the next edge.
    en   = 1'b0;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack4 != '0) acks++;
    end
    chk("en0 acks", acks, 0);
    en = 1'b1;
    rd4("en1", 1, 3);

    // Reset pulsed mid-gap clears outputs at once; read 1 edge after release.
    tick();
    rstx = 1'b0;
    #1;
    chk("midrst ack", ack4, 0);
    chk("midrst dv", dv4, 0);
    chk("midrst q", q4, 0);
    chk("midrst ch", ch4, 0);
    tick();
    rstx = 1'b1;
    rd4("postrst", 1, 0);

    // Maximum gap: 2 + 255 + 1 = 258 cycles.
    cfg_gap = 8'd255;
    rd4("max1", 3, 3);
    cfg_gap = 8'd0;
    rd4("max2", 258, 0);
    rd4("max3", 3, 3);

`ifdef FIFORDR_READY_EN
    // Backpressure: output holds, no new strobe, gap runs out underneath.
    ready = 1'b0;
    acks  = 0;
    lq    = q4;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack4 != '0) acks++;
      chk($sformatf("hold dv c%0d", k), dv4, 1);
      chk($sformatf("hold q c%0d", k), q4, lq);
      chk($sformatf("hold ch c%0d", k), ch4, 3);
    end
    chk("hold acks", acks, 0);
    ready = 1'b1;
    rd4("release", 1, 0);
`else
    // Legacy pulse: outputs fall back to 0 the cycle after a read.
    lq = q4;
    tick();
    chk("pulse dv", dv4, 0);
    chk("pulse q", q4, 0);
    chk("pulse ch", ch4, 0);
    chk("pulse ack", ack4, 0);
    chk("pulse prev q", lq, 8'hC3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
